// File: rtl/proc_core_param.sv
// Parametrised multi-cycle processor core: register file, ALU and a one-hot
// T0..T3 tick controller behind a valid/ready instruction handshake.
module proc_core_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int RA_W    = $clog2(NUM_REGS),
  localparam int IR_W    = 3 + 2 * RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [IR_W-1:0]   instr_ir,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [3:0]        tick,
  output logic              busy,
  output logic              done,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] T0 = 4'b0001;
  localparam logic [3:0] T1 = 4'b0010;
  localparam logic [3:0] T2 = 4'b0100;
  localparam logic [3:0] T3 = 4'b1000;

  localparam logic [2:0] OP_DISP = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_MOVI = 3'b111;

  localparam logic [DATA_W:0] SHIFT_LIM = (DATA_W + 1)'(DATA_W);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [IR_W-1:0]     ir;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   g;
  logic                c;

  logic [2:0]          op;
  logic [RA_W-1:0]     rx;
  logic [RA_W-1:0]     ry;
  logic [DATA_W-1:0]   b;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic                big_shift;
  logic [DATA_W-1:0]   alu_g;
  logic                alu_c;

  assign op = ir[IR_W-1 -: 3];
  assign rx = ir[2*RA_W-1 -: RA_W];
  assign ry = ir[RA_W-1:0];

  assign instr_ready = (tick == T0);
  assign busy        = (tick != T0);
  assign disp_valid  = (tick == T1) && (op == OP_DISP);
  assign done        = (tick == T3) || ((tick == T1) && (op == OP_MOVI || op == OP_DISP));
  assign dbg_data    = regs[dbg_addr];

  // Shift amounts are the full unsigned B value; anything >= DATA_W clears the result.
  always_comb begin
    b         = (op == OP_ADDI) ? imm : regs[ry];
    sum       = {1'b0, a} + {1'b0, b};
    prod      = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    big_shift = ({1'b0, b} >= SHIFT_LIM);
    alu_g     = '0;
    alu_c     = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        alu_g = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      OP_SUB: begin
        alu_g = a - b;
        alu_c = (a < b);
      end
      OP_MUL: begin
        alu_g = prod[DATA_W-1:0];
        alu_c = |prod[2*DATA_W-1:DATA_W];
      end
      OP_SRL:  alu_g = big_shift ? '0 : (a >> b);
      OP_SLL:  alu_g = big_shift ? '0 : (a << b);
      default: alu_g = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick      <= T0;
      ir        <= '0;
      imm       <= '0;
      a         <= '0;
      g         <= '0;
      c         <= 1'b0;
      disp_data <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (tick)
        T0: begin
          if (instr_valid) begin
            ir   <= instr_ir;
            imm  <= instr_imm;
            tick <= T1;
          end
        end
        T1: begin
          if (op == OP_MOVI) begin
            regs[rx] <= imm;
            tick     <= T0;
          end else if (op == OP_DISP) begin
            disp_data <= regs[rx];
            tick      <= T0;
          end else begin
            a    <= regs[rx];
            tick <= T2;
          end
        end
        T2: begin
          g    <= alu_g;
          c    <= alu_c;
          tick <= T3;
        end
        T3: begin
          regs[rx] <= g;
          flag_z   <= (g == '0);
          flag_c   <= c;
          tick     <= T0;
        end
        default: tick <= T0;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core_param.sv
// Randomised and directed bench for proc_core_param against an arithmetic
// reference model; a second 8-bit/4-register instance covers narrow wrapping.
module tb_proc_core_param;

  localparam logic [2:0] OP_DISP = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_MOVI = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [8:0]  instr_ir;
  logic [15:0] instr_imm;
  logic [3:0]  tick;
  logic        busy, done, disp_valid, flag_z, flag_c;
  logic [15:0] disp_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  logic        s_valid, s_ready, s_busy, s_done, s_disp_valid, s_z, s_c;
  logic [6:0]  s_ir;
  logic [7:0]  s_imm, s_disp_data, s_dbg_data;
  logic [3:0]  s_tick;
  logic [1:0]  s_dbg_addr;

  int checks = 0;
  int fails  = 0;

  longint unsigned mreg [8];
  logic            mz, mc;
  longint unsigned mdisp;

  always #5 clk = ~clk;

  proc_core_param dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_ir(instr_ir), .instr_imm(instr_imm), .tick(tick), .busy(busy), .done(done),
    .disp_valid(disp_valid), .disp_data(disp_data), .flag_z(flag_z), .flag_c(flag_c),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  proc_core_param #(.DATA_W(8), .NUM_REGS(4)) dut_small (
    .clk(clk), .rst(rst), .instr_valid(s_valid), .instr_ready(s_ready),
    .instr_ir(s_ir), .instr_imm(s_imm), .tick(s_tick), .busy(s_busy), .done(s_done),
    .disp_valid(s_disp_valid), .disp_data(s_disp_data), .flag_z(s_z), .flag_c(s_c),
    .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: instruction semantics as plain 64-bit arithmetic, masked to 16 bits.
  task automatic modelExec(input logic [2:0] op, input int rx, input int ry, input logic [15:0] imm);
    longint unsigned av, bv, r;
    logic cc;
    av = mreg[rx];
    bv = (op == OP_ADDI) ? 64'(imm) : mreg[ry];
    cc = 1'b0;
    case (op)
      OP_DISP: begin mdisp = av; return; end
      OP_MOVI: begin mreg[rx] = 64'(imm); return; end
      OP_ADD, OP_ADDI: begin r = av + bv; cc = (r > 64'hFFFF); end
      OP_SUB: begin r = av - bv; cc = (av < bv); end
      OP_MUL: begin r = av * bv; cc = ((r >> 16) != 0); end
      OP_SRL: r = (bv >= 16) ? 0 : (av >> bv);
      default: r = (bv >= 16) ? 0 : (av << bv);
    endcase
    r        = r & 64'hFFFF;
    mreg[rx] = r;
    mz       = (r == 0);
    mc       = cc;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input int rx, input int ry, input logic [15:0] imm);
    int n;
    int want;
    @(negedge clk);
    instr_ir    = {op, 3'(rx), 3'(ry)};
    instr_imm   = imm;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_in_t0", instr_ready, 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_ir    = 9'($urandom);
    instr_imm   = 16'($urandom);
    want = (op == OP_MOVI || op == OP_DISP) ? 1 : 3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= 3) begin
        checkOutput("tick_walk", tick, 64'(4'b0001 << n));
        checkOutput("busy", busy, 1);
      end
    end while (!done && n < 6);
    checkOutput("done_latency", n, want);
    checkOutput("disp_valid", disp_valid, (op == OP_DISP));
    modelExec(op, rx, ry, imm);
    @(negedge clk);
    checkOutput("tick_idle", tick, 4'b0001);
    checkOutput("done_idle", done, 0);
    dbg_addr = 3'(rx);
    #1;
    checkOutput("reg_rx", dbg_data, mreg[rx]);
    checkOutput("flag_z", flag_z, mz);
    checkOutput("flag_c", flag_c, mc);
    checkOutput("disp_data", disp_data, mdisp);
  endtask

  task automatic checkReg(input string tag, input int r, input logic [15:0] exp);
    dbg_addr = 3'(r);
    #1;
    checkOutput(tag, dbg_data, exp);
  endtask

  task automatic applySmall(input logic [2:0] op, input int rx, input int ry, input logic [7:0] imm);
    int n;
    @(negedge clk);
    s_ir    = {op, 2'(rx), 2'(ry)};
    s_imm   = imm;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    checkOutput("small_ready", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_done && n < 6);
    checkOutput("small_latency", n, (op == OP_MOVI || op == OP_DISP) ? 1 : 3);
    @(negedge clk);
  endtask

  task automatic checkSmall(input string tag, input int r, input logic [7:0] exp, input logic z, input logic cf);
    s_dbg_addr = 2'(r);
    #1;
    checkOutput(tag, s_dbg_data, exp);
    checkOutput({tag, "_z"}, s_z, z);
    checkOutput({tag, "_c"}, s_c, cf);
  endtask

  initial begin
    int acc, dn, dv, consec;
    logic prev_dv;
    logic [2:0] op;
    logic [15:0] imm;

    rst = 1'b1;
    instr_valid = 1'b0; instr_ir = '0; instr_imm = '0; dbg_addr = '0;
    s_valid = 1'b0; s_ir = '0; s_imm = '0; s_dbg_addr = '0;
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    mz = 0; mc = 0; mdisp = 0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_tick", tick, 4'b0001);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_disp_valid", disp_valid, 0);
    checkOutput("rst_disp_data", disp_data, 0);
    checkOutput("rst_flags", {flag_z, flag_c}, 0);
    checkOutput("rst_ready", instr_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed sequences");
    applyStimulus(OP_MOVI, 1, 0, 16'h0005);
    checkReg("movi_r1", 1, 16'h0005);
    checkOutput("movi_flags", {flag_z, flag_c}, 0);

    applyStimulus(OP_MOVI, 2, 0, 16'hFFFF);
    applyStimulus(OP_MOVI, 3, 0, 16'h0001);
    applyStimulus(OP_ADD, 2, 3, 16'h1234);
    checkReg("add_wrap", 2, 16'h0000);
    checkOutput("add_wrap_zc", {flag_z, flag_c}, 2'b11);

    applyStimulus(OP_MOVI, 4, 0, 16'h0003);
    applyStimulus(OP_MOVI, 5, 0, 16'h0005);
    applyStimulus(OP_SUB, 4, 5, 16'h0000);
    checkReg("sub_borrow", 4, 16'hFFFE);
    checkOutput("sub_borrow_zc", {flag_z, flag_c}, 2'b01);
    applyStimulus(OP_MUL, 4, 4, 16'h0000);
    checkReg("mul_self", 4, 16'h0004);
    checkOutput("mul_self_zc", {flag_z, flag_c}, 2'b01);

    applyStimulus(OP_MOVI, 6, 0, 16'h8001);
    applyStimulus(OP_MOVI, 7, 0, 16'h0001);
    applyStimulus(OP_SRL, 6, 7, 16'h0000);
    checkReg("srl_1", 6, 16'h4000);
    applyStimulus(OP_MOVI, 7, 0, 16'h0010);
    applyStimulus(OP_SLL, 6, 7, 16'h0000);
    checkReg("sll_16", 6, 16'h0000);
    checkOutput("sll_16_zc", {flag_z, flag_c}, 2'b10);
    applyStimulus(OP_ADDI, 1, 0, 16'hFFFF);
    checkReg("addi_wrap", 1, 16'h0004);
    applyStimulus(OP_ADD, 1, 1, 16'h0000);
    checkReg("add_double", 1, 16'h0008);
    applyStimulus(OP_MOVI, 1, 0, 16'h0005);

    // A source holding valid gets one accept per completed instruction.
    @(negedge clk);
    instr_ir = {OP_DISP, 3'd1, 3'd0};
    instr_valid = 1'b1;
    acc = 0; dn = 0; dv = 0; consec = 0; prev_dv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      acc += int'(instr_ready && instr_valid);
      dn  += int'(done);
      dv  += int'(disp_valid);
      if (disp_valid && prev_dv) consec++;
      prev_dv = disp_valid;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    checkOutput("hold_accepts", acc, 3);
    checkOutput("hold_dones", dn, 3);
    checkOutput("hold_disp_pulses", dv, 3);
    checkOutput("hold_consecutive", consec, 0);
    checkOutput("hold_disp_data", disp_data, 16'h0005);
    checkOutput("hold_tick", tick, 4'b0001);
    mdisp = 64'h5;

    // Reset in T2 of an ADDI aborts it with no writeback.
    @(negedge clk);
    instr_ir = {OP_ADDI, 3'd1, 3'd0};
    instr_imm = 16'h0007;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_t1", tick, 4'b0010);
    @(negedge clk);
    checkOutput("abort_t2", tick, 4'b0100);
    rst = 1'b1;
    #1;
    checkOutput("abort_tick", tick, 4'b0001);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_disp", disp_data, 0);
    for (int i = 0; i < 8; i++) checkReg("abort_reg", i, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkReg("abort_no_wb", 1, 16'h0000);
    checkOutput("abort_idle", tick, 4'b0001);
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    mz = 0; mc = 0; mdisp = 0;

    $display("[TB] random sequence");
    for (int k = 0; k < 40; k++) begin
      op  = 3'($urandom_range(0, 7));
      imm = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      applyStimulus(op, $urandom_range(0, 7), $urandom_range(0, 7), imm);
    end

    $display("[TB] narrow instance");
    applySmall(OP_MOVI, 2, 0, 8'hFF);
    applySmall(OP_MOVI, 3, 0, 8'h01);
    applySmall(OP_ADD, 2, 3, 8'h00);
    checkSmall("s_add_wrap", 2, 8'h00, 1'b1, 1'b1);
    applySmall(OP_MOVI, 0, 0, 8'h81);
    applySmall(OP_MOVI, 1, 0, 8'h01);
    applySmall(OP_SRL, 0, 1, 8'h00);
    checkSmall("s_srl_1", 0, 8'h40, 1'b0, 1'b0);
    applySmall(OP_MOVI, 1, 0, 8'h08);
    applySmall(OP_SLL, 0, 1, 8'h00);
    checkSmall("s_sll_8", 0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
